// File: rtl/spike_rate_encoder_pkg.sv
// -----------------------------------------------------------------------------
// spike_rate_encoder_pkg
//
// Shared definitions for the spike rate encoder:
//   - default channel count, intensity width and window length
//   - FSM state encoding (IDLE=0, CLEAR=1, RUN=2, 2-bit)
//   - helper that sizes the timestep counter
// -----------------------------------------------------------------------------
package spike_rate_encoder_pkg;

  localparam int DEF_N_CH   = 3;   // matches the 3-input neuron wrapper
  localparam int DEF_I_BITS = 4;   // intensity width per channel
  localparam int DEF_WINDOW = 16;  // timesteps per frame

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } state_e;

  // Width of the timestep counter: enough to hold WINDOW-1, never below 1 bit
  // so a single-step window still has a legal counter.
  function automatic int step_width(input int window);
    return (window > 1) ? $clog2(window) : 1;
  endfunction

endpackage : spike_rate_encoder_pkg

// File: rtl/spike_rate_encoder_sd_channel.sv
// -----------------------------------------------------------------------------
// spike_rate_encoder_sd_channel
//
// One first-order sigma-delta rate coder. The intensity is captured on load;
// on every step the accumulator adds the intensity and the carry out of that
// I_BITS-wide addition is the spike. Over 2^I_BITS steps the carry count
// equals the intensity, over WINDOW steps it is floor(WINDOW*val/2^I_BITS).
//
// Ports
//   clk      in   clock, all state changes on posedge
//   reset    in   synchronous active-high reset
//   load_i   in   capture val_i and clear the accumulator
//   step_i   in   advance one timestep (encoder in RUN)
//   val_i    in   intensity to capture, unsigned I_BITS
//   spike_o  out  spike for the current timestep (only while step_i)
// -----------------------------------------------------------------------------
module spike_rate_encoder_sd_channel
  import spike_rate_encoder_pkg::*;
#(
  parameter int I_BITS = DEF_I_BITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [I_BITS-1:0] val_i,
  output logic              spike_o
);

  logic [I_BITS-1:0] val_q, val_d;
  logic [I_BITS-1:0] acc_q, acc_d;
  logic [I_BITS:0]   sum;

  // One extra bit holds the carry; the low bits wrap modulo 2^I_BITS by design.
  assign sum     = {1'b0, acc_q} + {1'b0, val_q};
  assign spike_o = step_i & sum[I_BITS];

  // NOTE: every variable gets its hold value before any branch, so a path
  // that assigns nothing cannot infer a latch.
  always_comb begin
    val_d = val_q;
    acc_d = acc_q;
    if (load_i) begin
      val_d = val_i;
      acc_d = '0;
    end else if (step_i) begin
      acc_d = sum[I_BITS-1:0];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      val_q <= '0;
      acc_q <= '0;
    end else begin
      val_q <= val_d;
      acc_q <= acc_d;
    end
  end

endmodule : spike_rate_encoder_sd_channel

// File: rtl/spike_rate_encoder.sv
// -----------------------------------------------------------------------------
// spike_rate_encoder
//
// Turns a frame of N_CH intensities into N_CH spike trains of WINDOW
// timesteps. Each accepted frame runs CLEAR (one cycle, net_reset pulse to the
// downstream neurons) followed by RUN (WINDOW cycles of sigma-delta spikes).
// Frame-to-frame period is WINDOW+2 cycles when the producer holds in_valid.
//
// Ports
//   clk         in   clock, all state changes on posedge
//   reset       in   synchronous active-high reset
//   in_valid    in   frame offered
//   in_ready    out  encoder can accept a frame (IDLE and not in reset)
//   in_data     in   packed intensities, channel i at [i*I_BITS +: I_BITS]
//   spikes      out  spike per channel for the current timestep
//   net_reset   out  one-cycle clear pulse for the downstream neurons
//   frame_done  out  high during the last RUN timestep
//   busy        out  frame in progress (CLEAR or RUN)
//
// All outputs except in_ready come from registered state only.
// -----------------------------------------------------------------------------
module spike_rate_encoder
  import spike_rate_encoder_pkg::*;
#(
  parameter int N_CH   = DEF_N_CH,
  parameter int I_BITS = DEF_I_BITS,
  parameter int WINDOW = DEF_WINDOW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_CH*I_BITS-1:0] in_data,
  output logic [N_CH-1:0]        spikes,
  output logic                   net_reset,
  output logic                   frame_done,
  output logic                   busy
);

  localparam int STEP_W = step_width(WINDOW);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WINDOW - 1);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              accept;
  logic              run;
  logic              last_step;

  // ---------------------------------------------------------------------------
  // Handshake. in_ready is forced low during reset so nothing is accepted on
  // the reset edge.
  // ---------------------------------------------------------------------------
  assign in_ready  = (state_q == IDLE) && !reset;
  assign accept    = in_valid && in_ready;
  assign run       = (state_q == RUN);
  assign last_step = (step_q == LAST_STEP);

  // ---------------------------------------------------------------------------
  // FSM next state and step counter
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = CLEAR;
          step_d  = '0;
        end
      end
      CLEAR: begin
        state_d = RUN;
      end
      RUN: begin
        step_d = step_q + 1'b1;
        if (last_step) begin
          state_d = IDLE;
          step_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. net_reset occupies the CLEAR cycle, so it never overlaps step 0
  // spikes; the synchronous neuron reset takes effect before they arrive.
  // ---------------------------------------------------------------------------
  assign net_reset  = (state_q == CLEAR);
  assign frame_done = run && last_step;
  assign busy       = (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // One sigma-delta coder per channel. Intensities are captured only at
  // acceptance; in_data is ignored during CLEAR/RUN.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    spike_rate_encoder_sd_channel #(
      .I_BITS (I_BITS)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .load_i  (accept),
      .step_i  (run),
      .val_i   (in_data[i*I_BITS +: I_BITS]),
      .spike_o (spikes[i])
    );
  end

endmodule : spike_rate_encoder

// File: tb/tb_spike_rate_encoder.sv
// -----------------------------------------------------------------------------
// tb_spike_rate_encoder
//
// Bench for spike_rate_encoder: a WINDOW=16 instance with a behavioural LIF
// neuron on its spikes/net_reset, and a WINDOW=10 instance for the short
// window case. Expected spike vectors are queued at acceptance from the
// closed form floor((t+1)*v/16) - floor(t*v/16) and popped every RUN cycle.
// -----------------------------------------------------------------------------
module tb_spike_rate_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [11:0] in_data;
  logic [2:0]  spikes;
  logic        net_reset, frame_done, busy;

  logic        in_valid_b, in_ready_b;
  logic [11:0] in_data_b;
  logic [2:0]  spikes_b;
  logic        net_reset_b, frame_done_b, busy_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spike_rate_encoder #(.N_CH(3), .I_BITS(4), .WINDOW(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .spikes     (spikes),
    .net_reset  (net_reset),
    .frame_done (frame_done),
    .busy       (busy)
  );

  spike_rate_encoder #(.N_CH(3), .I_BITS(4), .WINDOW(10)) u_w10 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid_b),
    .in_ready   (in_ready_b),
    .in_data    (in_data_b),
    .spikes     (spikes_b),
    .net_reset  (net_reset_b),
    .frame_done (frame_done_b),
    .busy       (busy_b)
  );

  // ---------------------------------------------------------------------------
  // Behavioural 3-input LIF neuron driven by the encoder (loopback)
  // ---------------------------------------------------------------------------
  logic [7:0] nv_q;
  logic       nfire_q;

  function automatic logic [8:0] lif_next(input logic [7:0] v, input logic [2:0] s);
    int n;
    n = int'(v) - int'(v >> 3) + (s[0] ? 4 : 0) + (s[1] ? 6 : 0) + (s[2] ? 8 : 0);
    if (n >= 24) return {1'b1, 8'd0};
    return {1'b0, 8'(n)};
  endfunction

  always @(posedge clk) begin
    if (reset || net_reset) {nfire_q, nv_q} <= 9'd0;
    else                    {nfire_q, nv_q} <= lif_next(nv_q, spikes);
  end

  // ---------------------------------------------------------------------------
  // Scoreboard for the WINDOW=16 instance
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [2:0] spk;
    logic       done;
  } exp_t;

  exp_t exp_q[$];

  function automatic logic [2:0] exp_spk(input logic [11:0] d, input int t);
    logic [2:0] r;
    int v;
    for (int i = 0; i < 3; i++) begin
      v    = int'(d[i*4 +: 4]);
      r[i] = (((t + 1) * v) / 16) != ((t * v) / 16);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1 && net_reset === 1'b0) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: RUN cycle %0d with no expected step queued", cyc);
      end else begin
        e = exp_q.pop_front();
        if ({spikes, frame_done} !== {e.spk, e.done}) begin
          n_fail++;
          $display("FAIL sb_step: cycle %0d spikes/done got %b/%b want %b/%b",
                   cyc, spikes, frame_done, e.spk, e.done);
        end
      end
    end
    if (in_valid === 1'b1 && in_ready === 1'b1) begin
      for (int t = 0; t < 16; t++) exp_q.push_back('{spk: exp_spk(in_data, t), done: (t == 15)});
    end
  end

  // obs = {busy, in_ready, net_reset, frame_done, spikes}
  wire [6:0] obs = {busy, in_ready, net_reset, frame_done, spikes};

  task automatic wait_idle(input string who);
    int g;
    g = 0;
    while ((busy !== 1'b0 || busy_b !== 1'b0) && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_idle_timeout: busy=%b busy_b=%b want 0", who, busy, busy_b);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b1; in_data = 12'hFFF;
    in_valid_b = 1'b0; in_data_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (obs !== 7'b0 || busy_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: obs %b busy_b %b want 0000000 0", obs, busy_b);
    end
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== 7'b0100000) begin
      n_fail++;
      $display("FAIL reset_release: obs %b want 0100000", obs);
    end
  endtask

  task automatic test_counts;
    int c[3];
    c = '{0, 0, 0};
    @(posedge clk); #1;
    in_data = {4'd15, 4'd5, 4'd0}; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 12'hABC;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_checks++;
        if (obs !== 7'b1010000) begin
          n_fail++;
          $display("FAIL counts_clear: obs %b want 1010000", obs);
        end
      end else if (k <= 17) begin
        n_checks++;
        if ({busy, in_ready, net_reset, frame_done} !== {3'b100, (k == 17)}) begin
          n_fail++;
          $display("FAIL counts_run_k%0d: b/r/nr/fd %b want %b", k,
                   {busy, in_ready, net_reset, frame_done}, {3'b100, (k == 17)});
        end
        for (int i = 0; i < 3; i++) c[i] += int'(spikes[i]);
      end else begin
        n_checks++;
        if (obs !== 7'b0100000) begin
          n_fail++;
          $display("FAIL counts_idle: obs %b want 0100000", obs);
        end
      end
    end
    n_checks++;
    if (c[0] != 0 || c[1] != 5 || c[2] != 15) begin
      n_fail++;
      $display("FAIL counts_total: ch0/1/2 got %0d/%0d/%0d want 0/5/15", c[0], c[1], c[2]);
    end
  endtask

  task automatic test_half;
    logic [15:0] seen;
    seen = '0;
    @(posedge clk); #1;
    in_data = {4'd0, 4'd0, 4'd8}; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k >= 2) seen[k-2] = spikes[0];
    end
    n_checks++;
    if (seen !== 16'hAAAA) begin
      n_fail++;
      $display("FAIL half_pattern: steps %h want aaaa", seen);
    end
    @(negedge clk);
    n_checks++;
    if (dut.g_ch[0].u_ch.acc_q !== 4'd0) begin
      n_fail++;
      $display("FAIL half_acc_end: acc %0d want 0", dut.g_ch[0].u_ch.acc_q);
    end
  endtask

  task automatic test_back_to_back;
    int acc_cyc[4];
    int n_acc, guard;
    n_acc = 0; guard = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 12'($urandom);
    while (n_acc < 4 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (busy === 1'b1) begin
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_ready_busy: cycle %0d in_ready %b want 0", cyc, in_ready);
        end
      end
      if (in_valid && in_ready) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      @(posedge clk); #1;
      if (n_acc == 4) in_valid = 1'b0;
      else            in_data = 12'($urandom);
    end
    n_checks++;
    if (n_acc != 4) begin
      n_fail++;
      $display("FAIL b2b_accepts: got %0d accepts want 4", n_acc);
    end else begin
      for (int i = 1; i < 4; i++) begin
        n_checks++;
        if (acc_cyc[i] - acc_cyc[i-1] != 18) begin
          n_fail++;
          $display("FAIL b2b_period%0d: got %0d want 18", i, acc_cyc[i] - acc_cyc[i-1]);
        end
      end
    end
    wait_idle("b2b");
  endtask

  task automatic test_reset_mid_run;
    @(posedge clk); #1;
    in_data = {4'd7, 4'd11, 4'd3}; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, in_ready, net_reset, frame_done} !== 4'b1000) begin
      n_fail++;
      $display("FAIL rst_step7: b/r/nr/fd %b want 1000", {busy, in_ready, net_reset, frame_done});
    end
    @(posedge clk); #1;
    exp_q.delete();
    @(negedge clk);
    n_checks++;
    if (obs !== 7'b0) begin
      n_fail++;
      $display("FAIL rst_abort: obs %b want 0000000", obs);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== 7'b0100000) begin
      n_fail++;
      $display("FAIL rst_after: obs %b want 0100000", obs);
    end
  endtask

  task automatic test_window10;
    int c[3];
    int cyc_a[2];
    int n_acc, n_done, guard;
    c = '{0, 0, 0}; n_acc = 0; n_done = 0; guard = 0;
    @(posedge clk); #1;
    in_valid_b = 1'b1; in_data_b = 12'hFFF;
    while (n_acc < 2 && guard < 100) begin
      @(negedge clk);
      guard++;
      if (n_acc == 1) begin
        if (busy_b && !net_reset_b) for (int i = 0; i < 3; i++) c[i] += int'(spikes_b[i]);
        if (frame_done_b) n_done++;
      end
      if (in_valid_b && in_ready_b) begin
        cyc_a[n_acc] = cyc;
        n_acc++;
      end
      @(posedge clk); #1;
      if (n_acc == 2) in_valid_b = 1'b0;
    end
    n_checks++;
    if (n_acc != 2 || cyc_a[1] - cyc_a[0] != 12) begin
      n_fail++;
      $display("FAIL w10_period: accepts %0d period %0d want 2 12", n_acc, cyc_a[1] - cyc_a[0]);
    end
    n_checks++;
    if (c[0] != 9 || c[1] != 9 || c[2] != 9 || n_done != 1) begin
      n_fail++;
      $display("FAIL w10_counts: %0d/%0d/%0d done %0d want 9/9/9 done 1", c[0], c[1], c[2], n_done);
    end
    wait_idle("w10");
  endtask

  task automatic test_loopback;
    logic [15:0] trace[3];
    for (int f = 0; f < 3; f++) begin
      @(posedge clk); #1;
      in_data = (f == 0) ? 12'hFFF : {4'd13, 4'd4, 4'd9};
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      trace[f] = '0;
      for (int k = 1; k <= 18; k++) begin
        @(negedge clk);
        if (k == 2) begin
          n_checks++;
          if (nv_q !== 8'd0) begin
            n_fail++;
            $display("FAIL loop_v0_f%0d: voltage %0d at step 0 want 0", f, nv_q);
          end
        end
        if (k >= 2 && k <= 17) trace[f][k-2] = nfire_q;
      end
    end
    n_checks++;
    if (trace[1] !== trace[2] || trace[1] === 16'h0) begin
      n_fail++;
      $display("FAIL loop_repeat: traces %h %h want equal and nonzero", trace[1], trace[2]);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    in_valid_b = 1'b0; in_data_b = '0;
    test_reset();
    test_counts();
    test_half();
    test_back_to_back();
    test_reset_mid_run();
    test_window10();
    test_loopback();
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d expected steps never observed, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_checks, n_fail);
    $fatal(1);
  end

endmodule : tb_spike_rate_encoder
